// File: rtl/rs_issue_queue.sv
// Reservation station: dual dispatch, CDB wakeup (including at dispatch), one issue per FU per cycle, flush.
// Define RS_OLDEST_FIRST_EN to select the oldest ready entry per FU; the default picks the lowest ready index.
module rs_issue_queue #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int CTRL_W = 17,
  parameter int FU_W   = 2,
  parameter int AGE_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   disp_valid,
  input  logic [2*FU_W-1:0]            disp_fu,
  input  logic [2*CTRL_W-1:0]          disp_ctrl,
  input  logic [2*PREG_W-1:0]          disp_prs1,
  input  logic [2*PREG_W-1:0]          disp_prs2,
  input  logic [2*PREG_W-1:0]          disp_prd,
  input  logic [1:0]                   disp_rdy1,
  input  logic [1:0]                   disp_rdy2,
  input  logic [2*DATA_W-1:0]          disp_op1,
  input  logic [2*DATA_W-1:0]          disp_op2,
  input  logic [2*ROB_W-1:0]           disp_rob,
  output logic                         disp_ready,
  input  logic [NUM_FU-1:0]            cdb_valid,
  input  logic [NUM_FU*PREG_W-1:0]     cdb_tag,
  input  logic [NUM_FU*DATA_W-1:0]     cdb_data,
  input  logic [NUM_FU-1:0]            fu_ready,
  output logic [NUM_FU-1:0]            iss_valid,
  output logic [NUM_FU*CTRL_W-1:0]     iss_ctrl,
  output logic [NUM_FU*DATA_W-1:0]     iss_op1,
  output logic [NUM_FU*DATA_W-1:0]     iss_op2,
  output logic [NUM_FU*ROB_W-1:0]      iss_rob,
  input  logic                         flush,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic              e_valid [DEPTH];
  logic [FU_W-1:0]   e_fu    [DEPTH];
  logic [CTRL_W-1:0] e_ctrl  [DEPTH];
  logic [PREG_W-1:0] e_prs1  [DEPTH];
  logic [PREG_W-1:0] e_prs2  [DEPTH];
  logic              e_rdy1  [DEPTH];
  logic              e_rdy2  [DEPTH];
  logic [DATA_W-1:0] e_op1   [DEPTH];
  logic [DATA_W-1:0] e_op2   [DEPTH];
  logic [ROB_W-1:0]  e_rob   [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  logic [AGE_W-1:0]  e_age   [DEPTH];
  logic [AGE_W-1:0]  best_age [NUM_FU];
`else
  localparam int unused_age_w = AGE_W;
`endif

  // Returns {hit, data}; tag 0 is the hardwired-ready register and never matches.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [PREG_W-1:0]        tag,
    input logic [NUM_FU-1:0]        vld,
    input logic [NUM_FU*PREG_W-1:0] tags,
    input logic [NUM_FU*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int b = 0; b < NUM_FU; b++) begin
      if (vld[b] && tags[b*PREG_W +: PREG_W] != '0 && tags[b*PREG_W +: PREG_W] == tag)
        r = {1'b1, data[b*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  logic [1:0]        acc;
  logic [PREG_W-1:0] d_prs1 [2];
  logic [PREG_W-1:0] d_prs2 [2];
  logic              d_h1   [2];
  logic              d_h2   [2];
  logic [DATA_W-1:0] d_c1   [2];
  logic [DATA_W-1:0] d_c2   [2];
  logic              d_r1   [2];
  logic              d_r2   [2];
  logic [DATA_W-1:0] d_v1   [2];
  logic [DATA_W-1:0] d_v2   [2];
  logic [IDX_W-1:0]  slot_idx [2];
  logic [IDX_W-1:0]  free0, free1;
  logic              f0_found, f1_found;
  logic [OCC_W-1:0]  n_acc, n_iss;

  logic              e_h1 [DEPTH];
  logic              e_h2 [DEPTH];
  logic [DATA_W-1:0] e_c1 [DEPTH];
  logic [DATA_W-1:0] e_c2 [DEPTH];

  logic [NUM_FU-1:0] sel_vld;
  logic [IDX_W-1:0]  sel_idx [NUM_FU];
  logic [DEPTH-1:0]  iss_clr;

  logic unused_prd;
  assign unused_prd = ^disp_prd[2*PREG_W-1:PREG_W];

  assign disp_ready = (occupancy <= OCC_W'(DEPTH - 2));
  assign acc[0] = disp_valid[0] && disp_ready && !flush;
  assign acc[1] = disp_valid[1] && disp_ready && !flush;
  assign n_acc  = OCC_W'(acc[0]) + OCC_W'(acc[1]);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      d_prs1[k] = disp_prs1[k*PREG_W +: PREG_W];
      d_prs2[k] = disp_prs2[k*PREG_W +: PREG_W];
      {d_h1[k], d_c1[k]} = cdb_lookup(d_prs1[k], cdb_valid, cdb_tag, cdb_data);
      {d_h2[k], d_c2[k]} = cdb_lookup(d_prs2[k], cdb_valid, cdb_tag, cdb_data);
      d_r1[k] = disp_rdy1[k] || d_h1[k];
      d_r2[k] = disp_rdy2[k] || d_h2[k];
      d_v1[k] = d_h1[k] ? d_c1[k] : disp_op1[k*DATA_W +: DATA_W];
      d_v2[k] = d_h2[k] ? d_c2[k] : disp_op2[k*DATA_W +: DATA_W];
    end
    // Slot 1 consuming slot 0's result cannot be ready yet, whatever rename claimed.
    if (acc[0] && disp_prd[PREG_W-1:0] != '0) begin
      if (d_prs1[1] == disp_prd[PREG_W-1:0] && !d_h1[1]) d_r1[1] = 1'b0;
      if (d_prs2[1] == disp_prd[PREG_W-1:0] && !d_h2[1]) d_r2[1] = 1'b0;
    end
  end

  always_comb begin
    free0    = '0;
    free1    = '0;
    f0_found = 1'b0;
    f1_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!e_valid[i]) begin
        if (!f0_found) begin
          free0    = IDX_W'(i);
          f0_found = 1'b1;
        end else if (!f1_found) begin
          free1    = IDX_W'(i);
          f1_found = 1'b1;
        end
      end
    end
    slot_idx[0] = free0;
    slot_idx[1] = acc[0] ? free1 : free0;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {e_h1[i], e_c1[i]} = cdb_lookup(e_prs1[i], cdb_valid, cdb_tag, cdb_data);
      {e_h2[i], e_c2[i]} = cdb_lookup(e_prs2[i], cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_comb begin
    sel_vld = '0;
    iss_clr = '0;
    n_iss   = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sel_idx[f] = '0;
`ifdef RS_OLDEST_FIRST_EN
      best_age[f] = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && e_rdy1[i] && e_rdy2[i] && e_fu[i] == FU_W'(f) && fu_ready[f]) begin
`ifdef RS_OLDEST_FIRST_EN
          // Strictly-greater keeps the lowest index on age ties.
          if (!sel_vld[f] || e_age[i] > best_age[f]) begin
            sel_vld[f]  = 1'b1;
            sel_idx[f]  = IDX_W'(i);
            best_age[f] = e_age[i];
          end
`else
          if (!sel_vld[f]) begin
            sel_vld[f] = 1'b1;
            sel_idx[f] = IDX_W'(i);
          end
`endif
        end
      end
      if (sel_vld[f]) begin
        iss_clr[sel_idx[f]] = 1'b1;
        n_iss = n_iss + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
      iss_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_valid[i] <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
        e_age[i]   <= '0;
`endif
      end
      if (rst) begin
        iss_ctrl <= '0;
        iss_op1  <= '0;
        iss_op2  <= '0;
        iss_rob  <= '0;
      end
    end else begin
      occupancy <= occupancy + n_acc - n_iss;
      iss_valid <= sel_vld;
      for (int f = 0; f < NUM_FU; f++) begin
        if (sel_vld[f]) begin
          iss_ctrl[f*CTRL_W +: CTRL_W] <= e_ctrl[sel_idx[f]];
          iss_op1[f*DATA_W +: DATA_W]  <= e_op1[sel_idx[f]];
          iss_op2[f*DATA_W +: DATA_W]  <= e_op2[sel_idx[f]];
          iss_rob[f*ROB_W +: ROB_W]    <= e_rob[sel_idx[f]];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i]) begin
          if (!e_rdy1[i] && e_h1[i]) begin
            e_rdy1[i] <= 1'b1;
            e_op1[i]  <= e_c1[i];
          end
          if (!e_rdy2[i] && e_h2[i]) begin
            e_rdy2[i] <= 1'b1;
            e_op2[i]  <= e_c2[i];
          end
`ifdef RS_OLDEST_FIRST_EN
          if (e_age[i] != '1) e_age[i] <= e_age[i] + 1'b1;
`endif
        end
        if (iss_clr[i]) e_valid[i] <= 1'b0;
      end
      // Dispatch targets are free in registered state, so they never collide with wakeup or issue.
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          e_valid[slot_idx[k]] <= 1'b1;
          e_fu[slot_idx[k]]    <= disp_fu[k*FU_W +: FU_W];
          e_ctrl[slot_idx[k]]  <= disp_ctrl[k*CTRL_W +: CTRL_W];
          e_prs1[slot_idx[k]]  <= d_prs1[k];
          e_prs2[slot_idx[k]]  <= d_prs2[k];
          e_rdy1[slot_idx[k]]  <= d_r1[k];
          e_rdy2[slot_idx[k]]  <= d_r2[k];
          e_op1[slot_idx[k]]   <= d_v1[k];
          e_op2[slot_idx[k]]   <= d_v2[k];
          e_rob[slot_idx[k]]   <= disp_rob[k*ROB_W +: ROB_W];
`ifdef RS_OLDEST_FIRST_EN
          e_age[slot_idx[k]]   <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue in its default build (lowest-index select, RS_OLDEST_FIRST_EN undefined).
// Issued payloads are matched against a scoreboard queue filled when instructions are dispatched.
module tb_rs_issue_queue;

  logic        clk;
  logic        rst;
  logic [1:0]  disp_valid;
  logic [3:0]  disp_fu;
  logic [33:0] disp_ctrl;
  logic [11:0] disp_prs1, disp_prs2, disp_prd;
  logic [1:0]  disp_rdy1, disp_rdy2;
  logic [63:0] disp_op1, disp_op2;
  logic [11:0] disp_rob;
  logic        disp_ready;
  logic [2:0]  cdb_valid;
  logic [17:0] cdb_tag;
  logic [95:0] cdb_data;
  logic [2:0]  fu_ready;
  logic [2:0]  iss_valid;
  logic [50:0] iss_ctrl;
  logic [95:0] iss_op1, iss_op2;
  logic [17:0] iss_rob;
  logic        flush;
  logic [4:0]  occupancy;

  rs_issue_queue dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_ctrl(disp_ctrl),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2), .disp_prd(disp_prd),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_op1(disp_op1), .disp_op2(disp_op2), .disp_rob(disp_rob),
    .disp_ready(disp_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_ctrl(iss_ctrl), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_rob(iss_rob),
    .flush(flush), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          fu;
    logic [5:0]  rob;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [16:0] ctrl;
  } exp_t;

  typedef struct {
    logic [1:0]  fu0, fu1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  m1;
    logic [4:0]  occ1;
    logic [2:0]  m2;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    disp_valid = '0; disp_fu = '0; disp_ctrl = '0;
    disp_prs1 = '0; disp_prs2 = '0; disp_prd = '0;
    disp_rdy1 = '0; disp_rdy2 = '0;
    disp_op1 = '0; disp_op2 = '0; disp_rob = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    flush = 1'b0;
  endtask

  task automatic slot(input int k, input logic [1:0] fu, input logic [5:0] prs1, input logic [5:0] prs2,
                      input logic [5:0] prd, input logic r1, input logic r2,
                      input logic [31:0] a, input logic [31:0] b, input logic [5:0] rob,
                      input logic [16:0] ctrl);
    disp_valid[k]           = 1'b1;
    disp_fu[k*2 +: 2]       = fu;
    disp_prs1[k*6 +: 6]     = prs1;
    disp_prs2[k*6 +: 6]     = prs2;
    disp_prd[k*6 +: 6]      = prd;
    disp_rdy1[k]            = r1;
    disp_rdy2[k]            = r2;
    disp_op1[k*32 +: 32]    = a;
    disp_op2[k*32 +: 32]    = b;
    disp_rob[k*6 +: 6]      = rob;
    disp_ctrl[k*17 +: 17]   = ctrl;
  endtask

  task automatic expect_iss(input int fu, input logic [5:0] rob, input logic [31:0] a,
                            input logic [31:0] b, input logic [16:0] ctrl);
    exp_t e;
    e.fu = fu; e.rob = rob; e.op1 = a; e.op2 = b; e.ctrl = ctrl;
    exp_q.push_back(e);
  endtask

  task automatic cdb(input int b, input logic [5:0] tag, input logic [31:0] data);
    cdb_valid[b]          = 1'b1;
    cdb_tag[b*6 +: 6]     = tag;
    cdb_data[b*32 +: 32]  = data;
  endtask

  // Every issue seen on any port must match the oldest outstanding expectation for that port.
  always @(negedge clk) begin
    if (!rst) begin
      for (int f = 0; f < 3; f++) begin
        if (iss_valid[f]) begin
          int hit;
          hit = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (hit < 0 && exp_q[j].fu == f) hit = j;
          checks++;
          if (hit < 0) begin
            errors++;
            $display("FAIL issue_unexpected fu%0d: got rob=%0d, expected no issue", f, iss_rob[f*6 +: 6]);
          end else begin
            if ({iss_rob[f*6 +: 6], iss_op1[f*32 +: 32], iss_op2[f*32 +: 32], iss_ctrl[f*17 +: 17]} !==
                {exp_q[hit].rob, exp_q[hit].op1, exp_q[hit].op2, exp_q[hit].ctrl}) begin
              errors++;
              $display("FAIL issue_payload fu%0d: got rob=%0d op1=%0h op2=%0h ctrl=%0h expected rob=%0d op1=%0h op2=%0h ctrl=%0h",
                       f, iss_rob[f*6 +: 6], iss_op1[f*32 +: 32], iss_op2[f*32 +: 32], iss_ctrl[f*17 +: 17],
                       exp_q[hit].rob, exp_q[hit].op1, exp_q[hit].op2, exp_q[hit].ctrl);
            end
            exp_q.delete(hit);
          end
        end
      end
    end
  end

  vec_t vt[4];

  initial begin
    vt[0] = '{2'd0, 2'd1, 32'd5, 32'd7, 32'd5, 32'd7, 3'b011, 5'd0, 3'b000};
    vt[1] = '{2'd2, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4, 3'b101, 5'd0, 3'b000};
    vt[2] = '{2'd1, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1, 3'b010, 5'd1, 3'b010};
    vt[3] = '{2'd2, 2'd2, 32'd11, 32'd22, 32'd33, 32'd44, 3'b100, 5'd1, 3'b100};

    clear_in();
    fu_ready = 3'b111;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_iss_valid", 64'(iss_valid), 64'd0);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_iss_op1", 64'(iss_op1[31:0]), 64'd0);

    // Ready pairs: issue one edge after dispatch, same-FU pairs drain one per cycle.
    for (int v = 0; v < 4; v++) begin
      slot(0, vt[v].fu0, 6'd0, 6'd0, 6'd50, 1'b1, 1'b1, vt[v].a0, vt[v].b0, 6'(2*v), 17'(256 + v));
      slot(1, vt[v].fu1, 6'd0, 6'd0, 6'd51, 1'b1, 1'b1, vt[v].a1, vt[v].b1, 6'(2*v + 1), 17'(512 + v));
      expect_iss(int'(vt[v].fu0), 6'(2*v), vt[v].a0, vt[v].b0, 17'(256 + v));
      expect_iss(int'(vt[v].fu1), 6'(2*v + 1), vt[v].a1, vt[v].b1, 17'(512 + v));
      tick();
      clear_in();
      chk("vec_occ_after_dispatch", 64'(occupancy), 64'd2);
      tick();
      chk("vec_iss_valid_first", 64'(iss_valid), 64'(vt[v].m1));
      chk("vec_occ_first", 64'(occupancy), 64'(vt[v].occ1));
      tick();
      chk("vec_iss_valid_second", 64'(iss_valid), 64'(vt[v].m2));
      chk("vec_occ_drained", 64'(occupancy), 64'd0);
    end

    // Slot 1 depends on slot 0 (tag 12); rename's stale ready bit must be overridden.
    slot(0, 2'd0, 6'd0, 6'd0, 6'd12, 1'b1, 1'b1, 32'd1, 32'd2, 6'd10, 17'h1);
    slot(1, 2'd1, 6'd12, 6'd0, 6'd13, 1'b1, 1'b1, 32'hDEAD, 32'd3, 6'd11, 17'h2);
    expect_iss(0, 6'd10, 32'd1, 32'd2, 17'h1);
    expect_iss(1, 6'd11, 32'h2A, 32'd3, 17'h2);
    tick();
    clear_in();
    tick();
    chk("dep_not_issued_early", 64'(iss_valid[1]), 64'd0);
    cdb(0, 6'd12, 32'h2A);
    tick();
    clear_in();
    chk("dep_not_issued_at_wake", 64'(iss_valid[1]), 64'd0);
    tick();
    chk("dep_issued_after_wake", 64'(iss_valid[1]), 64'd1);
    chk("dep_op1", 64'(iss_op1[63:32]), 64'h2A);
    tick();
    chk("dep_occ_drained", 64'(occupancy), 64'd0);

    // Wakeup on the same edge the instruction is written.
    slot(0, 2'd2, 6'd0, 6'd40, 6'd41, 1'b1, 1'b0, 32'd9, 32'hBAD, 6'd20, 17'h3);
    cdb(2, 6'd40, 32'h77);
    expect_iss(2, 6'd20, 32'd9, 32'h77, 17'h3);
    tick();
    clear_in();
    tick();
    chk("dispwake_issue", 64'(iss_valid), 64'b100);
    chk("dispwake_op2", 64'(iss_op2[95:64]), 64'h77);
    tick();
    chk("dispwake_occ", 64'(occupancy), 64'd0);

    // Older entry at index 3 and younger at index 0 wake together for FU2.
    slot(0, 2'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd30, 32'd31, 6'd30, 17'h4);
    slot(1, 2'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd32, 32'd33, 6'd31, 17'h5);
    expect_iss(0, 6'd30, 32'd30, 32'd31, 17'h4);
    expect_iss(1, 6'd31, 32'd32, 32'd33, 17'h5);
    tick();
    clear_in();
    slot(0, 2'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'h20, 32'h21, 6'd32, 17'h6);
    slot(1, 2'd2, 6'd31, 6'd0, 6'd0, 1'b0, 1'b1, 32'd0, 32'h33, 6'd33, 17'h7);
    expect_iss(1, 6'd32, 32'h20, 32'h21, 17'h6);
    tick();
    clear_in();
    slot(0, 2'd2, 6'd32, 6'd0, 6'd0, 1'b0, 1'b1, 32'd0, 32'h44, 6'd34, 17'h8);
    tick();
    clear_in();
    cdb(0, 6'd31, 32'h31);
    cdb(1, 6'd32, 32'h32);
    expect_iss(2, 6'd34, 32'h32, 32'h44, 17'h8);
    expect_iss(2, 6'd33, 32'h31, 32'h33, 17'h7);
    tick();
    clear_in();
    tick();
    chk("select_first_valid", 64'(iss_valid[2]), 64'd1);
    chk("select_first_rob", 64'(iss_rob[17:12]), 64'd34);
    tick();
    chk("select_second_valid", 64'(iss_valid[2]), 64'd1);
    chk("select_second_rob", 64'(iss_rob[17:12]), 64'd33);
    tick();
    chk("select_occ_drained", 64'(occupancy), 64'd0);

    // Fill to 15 with blocked FUs, then check dispatch is refused.
    fu_ready = 3'b000;
    for (int p = 0; p < 7; p++) begin
      slot(0, 2'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'(p), 32'(p), 6'(40 + p), 17'h9);
      slot(1, 2'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'(p), 32'(p), 6'(50 + p), 17'h9);
      tick();
      clear_in();
    end
    chk("fill_occ_14", 64'(occupancy), 64'd14);
    chk("fill_ready_at_14", 64'(disp_ready), 64'd1);
    slot(0, 2'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd0, 32'd0, 6'd60, 17'h9);
    tick();
    clear_in();
    chk("fill_occ_15", 64'(occupancy), 64'd15);
    chk("fill_not_ready_at_15", 64'(disp_ready), 64'd0);
    for (int p = 0; p < 2; p++) begin
      slot(0, 2'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd0, 32'd0, 6'd61, 17'h9);
      slot(1, 2'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd0, 32'd0, 6'd62, 17'h9);
      tick();
      chk("full_dispatch_ignored", 64'(occupancy), 64'd15);
    end
    clear_in();
    flush = 1'b1;
    tick();
    clear_in();
    chk("full_flush_occ", 64'(occupancy), 64'd0);
    chk("full_flush_iss", 64'(iss_valid), 64'd0);
    fu_ready = 3'b111;
    tick();
    tick();
    chk("full_flush_stays_empty", 64'(occupancy), 64'd0);

    // Flush with six blocked entries and a concurrent dispatch while FUs become ready.
    fu_ready = 3'b000;
    for (int p = 0; p < 3; p++) begin
      slot(0, 2'(p), 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd1, 32'd1, 6'(p), 17'hA);
      slot(1, 2'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd2, 32'd2, 6'(p + 8), 17'hA);
      tick();
      clear_in();
    end
    chk("flush_occ_6", 64'(occupancy), 64'd6);
    fu_ready = 3'b111;
    flush = 1'b1;
    slot(0, 2'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd3, 32'd3, 6'd20, 17'hB);
    slot(1, 2'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 32'd3, 32'd3, 6'd21, 17'hB);
    tick();
    clear_in();
    chk("flush_occ_0", 64'(occupancy), 64'd0);
    chk("flush_iss_valid_0", 64'(iss_valid), 64'd0);
    tick();
    tick();
    tick();
    chk("flush_no_late_issue", 64'(iss_valid), 64'd0);
    chk("flush_occ_stays_0", 64'(occupancy), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
